// File: rtl/gpr_if.sv
// Register-file port bundle: two combinational read ports and one write port.
// The datapath (decode/write-back) holds the master side; the register file
// holds the slave side. Signal names follow the MIPS datapath naming.
interface gpr_if;
  logic        WE;    // write enable
  logic [4:0]  RA;    // read address, port A (rs)
  logic [4:0]  RB;    // read address, port B (rt)
  logic [4:0]  RW;    // write address
  logic [31:0] WD;    // write data
  logic [31:0] BusA;  // reg[RA]
  logic [31:0] BusB;  // reg[RB]

  modport master (
    output WE, RA, RB, RW, WD,
    input  BusA, BusB
  );

  modport slave (
    input  WE, RA, RB, RW, WD,
    output BusA, BusB
  );
endinterface : gpr_if

// File: rtl/gpr.sv
// 32 x 32-bit MIPS general-purpose register file.
// Two asynchronous read ports, one synchronous write port, $0 hard-wired to
// zero, synchronous active-high clear of every entry. WRITE_BYPASS selects
// whether a same-cycle write is forwarded to a read of the same index.
module gpr #(
  parameter bit WRITE_BYPASS = 1'b0
) (
  input  logic  clk,
  input  logic  reset,
  gpr_if.slave  bus
);

  localparam int unsigned NREGS = 32;

  // Entries start at zero so reads are defined before the first reset.
  logic [31:0] regs_q [NREGS] = '{default: '0};
  logic [31:0] regs_d [NREGS];

  // A write commits only with WE set and a non-zero destination; $0 is never
  // stored, so its entry stays zero.
  logic write_hit;
  assign write_hit = bus.WE && (bus.RW != 5'd0);

  // Next-state of the array: copy current contents, then overlay the write.
  always_comb begin
    // NOTE: regs_d is fully assigned before the conditional overlay so that
    // every path defines every element and no latch is inferred.
    regs_d = regs_q;
    if (write_hit) begin
      regs_d[bus.RW] = bus.WD;
    end
  end

  // State update: reset clears every entry and wins over a same-cycle write.
  always_ff @(posedge clk) begin
    // NOTE: the architectural reset clears the whole file, so every entry is
    // reset here; a storage array without this behaviour would skip the reset.
    if (reset) begin
      regs_q <= '{default: '0};
    end else begin
      // NOTE: non-blocking assignment keeps the array update race-free with
      // the combinational readers sampling regs_q in the same time step.
      regs_q <= regs_d;
    end
  end

  // Forwarding is suppressed during reset and for $0 (write_hit excludes RW=0).
  logic bypass_ok;
  assign bypass_ok = WRITE_BYPASS && write_hit && !reset;

  // Read selection: forwarded write data, hard zero for $0, or stored value.
  function automatic logic [31:0] read_port(
    input logic [4:0]  addr,
    input logic        fwd_en,
    input logic [4:0]  waddr,
    input logic [31:0] wdata,
    input logic [31:0] stored
  );
    if (fwd_en && (waddr == addr)) begin
      return wdata;
    end else if (addr == 5'd0) begin
      return 32'h0000_0000;
    end else begin
      return stored;
    end
  endfunction

  // Combinational read ports; both may address the same register.
  assign bus.BusA = read_port(bus.RA, bypass_ok, bus.RW, bus.WD, regs_q[bus.RA]);
  assign bus.BusB = read_port(bus.RB, bypass_ok, bus.RW, bus.WD, regs_q[bus.RB]);

endmodule : gpr

// File: tb/tb_gpr.sv
// Self-checking bench for gpr. Two instances run in lockstep on the same
// stimulus: one without write bypass and one with it. A plain array model of
// the 32 registers predicts every read on both ports of both instances.
module tb_gpr;

  logic clk;
  logic reset;

  gpr_if if_nb ();
  gpr_if if_bp ();

  gpr #(.WRITE_BYPASS(1'b0)) dut_nb (.clk(clk), .reset(reset), .bus(if_nb));
  gpr #(.WRITE_BYPASS(1'b1)) dut_bp (.clk(clk), .reset(reset), .bus(if_bp));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference state and current stimulus.
  logic [31:0] model [32];
  logic        cur_we;
  logic [4:0]  cur_ra, cur_rb, cur_rw;
  logic [31:0] cur_wd;

  int checks   = 0;
  int failures = 0;

  // Write trace: every committed write except those to $0.
  always @(posedge clk) begin
    if (!reset && if_nb.WE && (if_nb.RW != 5'd0)) begin
      $display("%0t gpr write: $%0d <= 0x%08h", $time, if_nb.RW, if_nb.WD);
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, got, exp);
    end
  endtask

  // Expected read value for one port given the current inputs.
  function automatic logic [31:0] exp_read(input logic [4:0] addr, input bit bypass);
    if (addr == 5'd0) return 32'h0;
    if (bypass && !reset && cur_we && cur_rw != 5'd0 && cur_rw == addr) return cur_wd;
    return model[addr];
  endfunction

  task automatic check_all(input string tag);
    check({tag, "/nb_A"}, if_nb.BusA, exp_read(cur_ra, 1'b0));
    check({tag, "/nb_B"}, if_nb.BusB, exp_read(cur_rb, 1'b0));
    check({tag, "/bp_A"}, if_bp.BusA, exp_read(cur_ra, 1'b1));
    check({tag, "/bp_B"}, if_bp.BusB, exp_read(cur_rb, 1'b1));
  endtask

  task automatic drive(input logic we, input logic [4:0] ra, input logic [4:0] rb,
                       input logic [4:0] rw, input logic [31:0] wd, input logic rst);
    cur_we = we; cur_ra = ra; cur_rb = rb; cur_rw = rw; cur_wd = wd;
    reset  = rst;
    if_nb.WE = we; if_nb.RA = ra; if_nb.RB = rb; if_nb.RW = rw; if_nb.WD = wd;
    if_bp.WE = we; if_bp.RA = ra; if_bp.RB = rb; if_bp.RW = rw; if_bp.WD = wd;
  endtask

  // One clock cycle: drive at negedge, check before the edge, apply the
  // architectural effect of the edge to the model, check after the edge.
  task automatic step(input logic we, input logic [4:0] ra, input logic [4:0] rb,
                      input logic [4:0] rw, input logic [31:0] wd, input logic rst,
                      input string tag);
    @(negedge clk);
    drive(we, ra, rb, rw, wd, rst);
    #1 check_all({tag, "_pre"});
    @(posedge clk);
    if (rst) begin
      foreach (model[i]) model[i] = 32'h0;
    end else if (we && rw != 5'd0) begin
      model[rw] = wd;
    end
    #1 check_all({tag, "_post"});
  endtask

  initial begin
    foreach (model[i]) model[i] = 32'h0;
    drive(1'b0, 5'd7, 5'd31, 5'd0, 32'h0, 1'b0);

    // Power-up contents are zero before any reset.
    #1 check_all("powerup");

    // Write to $0 is discarded.
    step(1'b1, 5'd0, 5'd0, 5'd0, 32'd100, 1'b0, "wr_zero");

    // Basic write/read on port B.
    step(1'b1, 5'd0, 5'd10, 5'd10, 32'd100, 1'b0, "wr10");

    // Second write, read on port A, port B keeps reg10.
    step(1'b1, 5'd20, 5'd10, 5'd20, 32'd200, 1'b0, "wr20");

    // Write disabled: reg10 keeps 100.
    step(1'b0, 5'd20, 5'd10, 5'd10, 32'hDEAD_BEEF, 1'b0, "we_off");

    // Reset beats a simultaneous write.
    step(1'b1, 5'd5, 5'd10, 5'd5, 32'd7, 1'b1, "rst_prio");
    step(1'b0, 5'd5, 5'd20, 5'd0, 32'h0, 1'b0, "rst_rd5_20");
    for (int a = 0; a < 32; a += 2) begin
      step(1'b0, 5'(a), 5'(a + 1), 5'd0, 32'h0, 1'b0, $sformatf("rst_sweep%0d", a));
    end

    // Same-cycle read/write of one index: old value vs forwarded value.
    step(1'b1, 5'd0, 5'd0, 5'd3, 32'h11, 1'b0, "prime3");
    step(1'b1, 5'd3, 5'd3, 5'd3, 32'h55, 1'b0, "rw_same3");

    // Bypass must not forward during reset.
    step(1'b1, 5'd3, 5'd9, 5'd3, 32'h77, 1'b1, "bp_in_rst");

    // Randomized traffic with biased address collisions and occasional reset.
    for (int n = 0; n < 400; n++) begin
      logic        we, rst;
      logic [4:0]  ra, rb, rw;
      logic [31:0] wd;
      we  = 1'($urandom_range(0, 3) != 0);
      ra  = 5'($urandom_range(0, 31));
      rb  = 5'($urandom_range(0, 31));
      rw  = ($urandom_range(0, 3) == 0) ? ra : 5'($urandom_range(0, 31));
      wd  = $urandom;
      rst = 1'($urandom_range(0, 49) == 0);
      step(we, ra, rb, rw, wd, rst, $sformatf("rand%0d", n));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_gpr
